// File: rtl/pipe_fetch_decode_regs.sv
// Front-end pipeline registers: PC (F), IF/ID (D), ID/EX (E), and hazard-unit
// stall/flush handling, plus saturating stall/flush event counters.
module pipe_fetch_decode_regs #(
  parameter int          XLEN      = 32,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [XLEN-1:0]   PCNextF,
  input  logic [31:0]       InstrF,
  input  logic [XLEN-1:0]   PCPlus4F,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic [1:0]        ResultSrcD,
  input  logic [2:0]        ALUControlD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  output logic [XLEN-1:0]   PCF,
  output logic [31:0]       InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic [4:0]        Rs1D,
  output logic [4:0]        Rs2D,
  output logic [4:0]        RdD,
  output logic              ValidD,
  output logic              ValidE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [1:0]        ResultSrcE,
  output logic              ResultSrcE0,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [XLEN-1:0]  r_pc_f;
  logic [31:0]      r_instr_d;
  logic [XLEN-1:0]  r_pc_d;
  logic [XLEN-1:0]  r_pc_plus4_d;
  logic             r_valid_d;

  logic             r_valid_e;
  logic             r_reg_write_e;
  logic             r_mem_write_e;
  logic             r_jump_e;
  logic             r_branch_e;
  logic             r_alu_src_e;
  logic [1:0]       r_result_src_e;
  logic [2:0]       r_alu_control_e;
  logic [XLEN-1:0]  r_rd1_e;
  logic [XLEN-1:0]  r_rd2_e;
  logic [XLEN-1:0]  r_imm_ext_e;
  logic [XLEN-1:0]  r_pc_e;
  logic [XLEN-1:0]  r_pc_plus4_e;
  logic [4:0]       r_rs1_e;
  logic [4:0]       r_rs2_e;
  logic [4:0]       r_rd_e;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [4:0]       w_rs1_d;
  logic [4:0]       w_rs2_d;
  logic [4:0]       w_rd_d;
  logic             w_stall_sat;
  logic             w_flush_sat;

  assign w_rs1_d     = r_instr_d[19:15];
  assign w_rs2_d     = r_instr_d[24:20];
  assign w_rd_d      = r_instr_d[11:7];
  assign w_stall_sat = &r_stall_cnt;
  assign w_flush_sat = &r_flush_cnt;

  // F stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_f <= '0;
    end else if (!StallF) begin
      r_pc_f <= PCNextF;
    end
  end

  // D stage: flush wins over stall so a squashed instruction can never be held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else if (FlushD) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else if (!StallD) begin
      r_instr_d    <= InstrF;
      r_pc_d       <= r_pc_f;
      r_pc_plus4_d <= PCPlus4F;
      r_valid_d    <= 1'b1;
    end
  end

  // E stage: a bubble zeroes register indices too, so it never matches a hazard check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_e       <= 1'b0;
      r_reg_write_e   <= 1'b0;
      r_mem_write_e   <= 1'b0;
      r_jump_e        <= 1'b0;
      r_branch_e      <= 1'b0;
      r_alu_src_e     <= 1'b0;
      r_result_src_e  <= '0;
      r_alu_control_e <= '0;
      r_rd1_e         <= '0;
      r_rd2_e         <= '0;
      r_imm_ext_e     <= '0;
      r_pc_e          <= '0;
      r_pc_plus4_e    <= '0;
      r_rs1_e         <= '0;
      r_rs2_e         <= '0;
      r_rd_e          <= '0;
    end else if (FlushE) begin
      r_valid_e       <= 1'b0;
      r_reg_write_e   <= 1'b0;
      r_mem_write_e   <= 1'b0;
      r_jump_e        <= 1'b0;
      r_branch_e      <= 1'b0;
      r_alu_src_e     <= 1'b0;
      r_result_src_e  <= '0;
      r_alu_control_e <= '0;
      r_rd1_e         <= '0;
      r_rd2_e         <= '0;
      r_imm_ext_e     <= '0;
      r_pc_e          <= '0;
      r_pc_plus4_e    <= '0;
      r_rs1_e         <= '0;
      r_rs2_e         <= '0;
      r_rd_e          <= '0;
    end else begin
      r_valid_e       <= r_valid_d;
      r_reg_write_e   <= RegWriteD;
      r_mem_write_e   <= MemWriteD;
      r_jump_e        <= JumpD;
      r_branch_e      <= BranchD;
      r_alu_src_e     <= ALUSrcD;
      r_result_src_e  <= ResultSrcD;
      r_alu_control_e <= ALUControlD;
      r_rd1_e         <= RD1D;
      r_rd2_e         <= RD2D;
      r_imm_ext_e     <= ImmExtD;
      r_pc_e          <= r_pc_d;
      r_pc_plus4_e    <= r_pc_plus4_d;
      r_rs1_e         <= w_rs1_d;
      r_rs2_e         <= w_rs2_d;
      r_rd_e          <= w_rd_d;
    end
  end

  // Event counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF && !w_stall_sat) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (FlushE && !w_flush_sat) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign PCF         = r_pc_f;
  assign InstrD      = r_instr_d;
  assign PCD         = r_pc_d;
  assign PCPlus4D    = r_pc_plus4_d;
  assign Rs1D        = w_rs1_d;
  assign Rs2D        = w_rs2_d;
  assign RdD         = w_rd_d;
  assign ValidD      = r_valid_d;
  assign ValidE      = r_valid_e;
  assign RegWriteE   = r_reg_write_e;
  assign MemWriteE   = r_mem_write_e;
  assign JumpE       = r_jump_e;
  assign BranchE     = r_branch_e;
  assign ALUSrcE     = r_alu_src_e;
  assign ResultSrcE  = r_result_src_e;
  assign ResultSrcE0 = r_result_src_e[0];
  assign ALUControlE = r_alu_control_e;
  assign RD1E        = r_rd1_e;
  assign RD2E        = r_rd2_e;
  assign ImmExtE     = r_imm_ext_e;
  assign PCE         = r_pc_e;
  assign PCPlus4E    = r_pc_plus4_e;
  assign Rs1E        = r_rs1_e;
  assign Rs2E        = r_rs2_e;
  assign RdE         = r_rd_e;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_fetch_decode_regs.sv
// Directed bench for pipe_fetch_decode_regs with hand-computed expectations;
// counters are built 4 bits wide so saturation is reachable quickly.
module tb_pipe_fetch_decode_regs;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             StallF, StallD, FlushD, FlushE;
  logic [XLEN-1:0]  PCNextF, PCPlus4F;
  logic [31:0]      InstrF;
  logic             RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]       ResultSrcD;
  logic [2:0]       ALUControlD;
  logic [XLEN-1:0]  RD1D, RD2D, ImmExtD;
  logic [XLEN-1:0]  PCF, PCD, PCPlus4D;
  logic [31:0]      InstrD;
  logic [4:0]       Rs1D, Rs2D, RdD;
  logic             ValidD, ValidE;
  logic             RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]       ResultSrcE;
  logic             ResultSrcE0;
  logic [2:0]       ALUControlE;
  logic [XLEN-1:0]  RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pipe_fetch_decode_regs #(.XLEN(XLEN), .CNT_W(CNT_W), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .rst_n(rst_n),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ValidD(ValidD), .ValidE(ValidE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ResultSrcE0(ResultSrcE0),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmds(input logic sf, input logic sd, input logic fd, input logic fe);
    StallF = sf; StallD = sd; FlushD = fd; FlushE = fe;
  endtask

  task automatic fetch(input logic [31:0] pcn, input logic [31:0] ins, input logic [31:0] pc4);
    PCNextF = pcn; InstrF = ins; PCPlus4F = pc4;
  endtask

  initial begin
    rst_n = 1'b0;
    cmds(0, 0, 0, 0);
    fetch(0, 0, 0);
    RegWriteD = 1'b1; MemWriteD = 1'b0; JumpD = 1'b0; BranchD = 1'b1; ALUSrcD = 1'b1;
    ResultSrcD = 2'b01; ALUControlD = 3'b101;
    RD1D = 32'h0000AAAA; RD2D = 32'h00005555; ImmExtD = 32'h00000005;

    #12;
    chk("rst_pcf", PCF, 0);
    chk("rst_instrd", InstrD, 32'h00000013);
    chk("rst_validd", {31'b0, ValidD}, 0);
    chk("rst_valide", {31'b0, ValidE}, 0);
    chk("rst_rde", {27'b0, RdE}, 0);
    chk("rst_stallcnt", {28'b0, stall_cnt}, 0);
    chk("rst_flushcnt", {28'b0, flush_cnt}, 0);

    // straight-line flow; first edge after release is a normal load
    rst_n = 1'b1;
    fetch(32'h4, 32'h00500093, 32'h4);
    step();
    chk("sl1_pcf", PCF, 32'h4);
    chk("sl1_instrd", InstrD, 32'h00500093);
    chk("sl1_validd", {31'b0, ValidD}, 1);
    chk("sl1_valide", {31'b0, ValidE}, 0);

    fetch(32'h8, 32'h00108133, 32'h8);
    step();
    chk("sl2_instrd", InstrD, 32'h00108133);
    chk("sl2_pcd", PCD, 32'h4);
    chk("sl2_rde", {27'b0, RdE}, 1);
    chk("sl2_rs2e", {27'b0, Rs2E}, 5);
    chk("sl2_valide", {31'b0, ValidE}, 1);
    chk("sl2_regwre", {31'b0, RegWriteE}, 1);
    chk("sl2_rsrc0", {31'b0, ResultSrcE0}, 1);
    chk("sl2_rd1e", RD1E, 32'h0000AAAA);
    chk("sl2_alue", {29'b0, ALUControlE}, 5);

    fetch(32'hC, 32'h002081B3, 32'hC);
    step();
    chk("sl3_rs1d", {27'b0, Rs1D}, 1);
    chk("sl3_rs2d", {27'b0, Rs2D}, 2);
    chk("sl3_rdd", {27'b0, RdD}, 3);
    chk("sl3_rs1e", {27'b0, Rs1E}, 1);
    chk("sl3_rs2e", {27'b0, Rs2E}, 1);
    chk("sl3_rde", {27'b0, RdE}, 2);
    chk("sl3_pce", PCE, 32'h4);
    chk("sl3_pc4e", PCPlus4E, 32'h8);

    fetch(32'h10, 32'h0020A183, 32'h10);
    step();
    chk("sl4_instrd", InstrD, 32'h0020A183);
    chk("sl4_rde", {27'b0, RdE}, 3);

    // load-use bubble
    cmds(1, 1, 0, 1);
    fetch(32'h14, 32'h00000033, 32'h14);
    step();
    chk("lu_pcf", PCF, 32'h10);
    chk("lu_instrd", InstrD, 32'h0020A183);
    chk("lu_validd", {31'b0, ValidD}, 1);
    chk("lu_rde", {27'b0, RdE}, 0);
    chk("lu_rs1e", {27'b0, Rs1E}, 0);
    chk("lu_valide", {31'b0, ValidE}, 0);
    chk("lu_regwre", {31'b0, RegWriteE}, 0);
    chk("lu_rd1e", RD1E, 0);
    chk("lu_stallcnt", {28'b0, stall_cnt}, 1);
    chk("lu_flushcnt", {28'b0, flush_cnt}, 1);

    cmds(0, 0, 0, 0);
    step();
    chk("lu2_rs1e", {27'b0, Rs1E}, 1);
    chk("lu2_rs2e", {27'b0, Rs2E}, 2);
    chk("lu2_rde", {27'b0, RdE}, 3);
    chk("lu2_valide", {31'b0, ValidE}, 1);
    chk("lu2_pcf", PCF, 32'h14);
    chk("lu2_stallcnt", {28'b0, stall_cnt}, 1);

    // taken branch
    cmds(0, 0, 1, 1);
    fetch(32'h100, 32'h00108133, 32'h18);
    step();
    chk("br_pcf", PCF, 32'h100);
    chk("br_instrd", InstrD, 32'h00000013);
    chk("br_pcd", PCD, 0);
    chk("br_validd", {31'b0, ValidD}, 0);
    chk("br_valide", {31'b0, ValidE}, 0);
    chk("br_ctrl", {26'b0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE0}, 0);
    chk("br_flushcnt", {28'b0, flush_cnt}, 2);

    // flush-over-stall priority in D
    cmds(0, 0, 0, 0);
    fetch(32'h104, 32'h00108133, 32'h104);
    step();
    chk("pr0_instrd", InstrD, 32'h00108133);
    cmds(0, 1, 1, 0);
    fetch(32'h108, 32'h002081B3, 32'h108);
    step();
    chk("pr_instrd", InstrD, 32'h00000013);
    chk("pr_validd", {31'b0, ValidD}, 0);
    chk("pr_valide", {31'b0, ValidE}, 1);
    chk("pr_rde", {27'b0, RdE}, 2);

    // stall counter saturation (starts at 1)
    cmds(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 12) chk("sat_14", {28'b0, stall_cnt}, 14);
      if (i == 13) chk("sat_15", {28'b0, stall_cnt}, 15);
    end
    chk("sat_hold", {28'b0, stall_cnt}, 15);
    chk("sat_flushcnt", {28'b0, flush_cnt}, 2);
    chk("sat_valide", {31'b0, ValidE}, 1);

    // asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_pcf", PCF, 0);
    chk("ar_instrd", InstrD, 32'h00000013);
    chk("ar_valide", {31'b0, ValidE}, 0);
    chk("ar_stallcnt", {28'b0, stall_cnt}, 0);
    chk("ar_flushcnt", {28'b0, flush_cnt}, 0);
    step();
    chk("ar_hold_pcf", PCF, 0);
    rst_n = 1'b1;
    cmds(0, 0, 0, 0);
    fetch(32'h200, 32'h00500093, 32'h4);
    step();
    chk("rel_pcf", PCF, 32'h200);
    chk("rel_instrd", InstrD, 32'h00500093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
